// File: rtl/drs_pkg.sv
// Shared constants for the discrete range sampler: FSM encoding, LFSR taps, default widths.
package drs_pkg;

  localparam int unsigned DRS_NUM_VARS    = 4;
  localparam int unsigned DRS_MAX_VALUES  = 16;
  localparam int unsigned DRS_VALUE_WIDTH = 16;
  localparam int unsigned DRS_MAX_TRIES   = 4;

  localparam int unsigned LFSR_W = 16;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 16'h0001;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_SIZE   = 3'd1;
  localparam logic [STATE_W-1:0] S_DRAW   = 3'd2;
  localparam logic [STATE_W-1:0] S_LOOKUP = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE   = 3'd4;

  // Smear the highest set bit downwards, giving the smallest all-ones mask covering x
  function automatic logic [LFSR_W-1:0] smear(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/drs_lfsr.sv
// 16-bit Galois LFSR with seed load (zero seed maps to 1) taking priority over stepping.
module drs_lfsr
  import drs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_RESET;
    end else if (seed_load) begin
      state <= (seed == '0) ? LFSR_RESET : seed;
    end else if (en) begin
      state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/discrete_range_sampler.sv
// Draws a uniform table index for a variable by LFSR rejection sampling and returns its range.
// Optional DRS_EXCLUDE_CURRENT_EN: never return in_current_idx when the variable has >= 2 entries.
module discrete_range_sampler
  import drs_pkg::*;
#(
  parameter int unsigned NUM_VARS    = DRS_NUM_VARS,
  parameter int unsigned MAX_VALUES  = DRS_MAX_VALUES,
  parameter int unsigned VALUE_WIDTH = DRS_VALUE_WIDTH,
  parameter int unsigned MAX_TRIES   = DRS_MAX_TRIES
) (
  input  logic                            in_clock,
  input  logic                            in_reset_n,
  input  logic [15:0]                     in_seed,
  input  logic                            in_seed_load,
  input  logic                            in_wr_en,
  input  logic [$clog2(NUM_VARS)-1:0]     in_wr_var,
  input  logic [$clog2(MAX_VALUES)-1:0]   in_wr_idx,
  input  logic [VALUE_WIDTH-1:0]          in_wr_start,
  input  logic [VALUE_WIDTH-1:0]          in_wr_end,
  input  logic                            in_size_wr_en,
  input  logic [$clog2(MAX_VALUES):0]     in_size,
  input  logic                            in_valid,
  output logic                            out_ready,
  input  logic [$clog2(NUM_VARS)-1:0]     in_var,
  input  logic [$clog2(MAX_VALUES)-1:0]   in_current_idx,
  output logic                            out_valid,
  input  logic                            in_ready,
  output logic [VALUE_WIDTH-1:0]          out_start,
  output logic [VALUE_WIDTH-1:0]          out_end,
  output logic [$clog2(MAX_VALUES)-1:0]   out_index,
  output logic                            out_equal,
  output logic                            out_error
);

  localparam int unsigned VAR_W = $clog2(NUM_VARS);
  localparam int unsigned IDX_W = $clog2(MAX_VALUES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  logic [VALUE_WIDTH-1:0] tab_start [NUM_VARS][MAX_VALUES];
  logic [VALUE_WIDTH-1:0] tab_end   [NUM_VARS][MAX_VALUES];
  logic [CNT_W-1:0]       size_q    [NUM_VARS];

  logic [STATE_W-1:0]     state_q, state_d;
  logic [VAR_W-1:0]       var_q, var_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]       mask_q, mask_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   valid_d, ready_d, equal_d, error_d;
  logic [VALUE_WIDTH-1:0] start_d, end_d;
  logic [IDX_W-1:0]       index_d;

  logic [LFSR_W-1:0]      lfsr_q;
  logic                   lfsr_en;
  logic [IDX_W-1:0]       draw, fb_raw, fallback;
  logic [CNT_W-1:0]       draw_wide;
  logic                   draw_fits, draw_ok;
  logic                   unused_sig;

  drs_lfsr u_lfsr (
    .clk       (in_clock),
    .rst_n     (in_reset_n),
    .seed_load (in_seed_load),
    .seed      (in_seed),
    .en        (lfsr_en),
    .state     (lfsr_q)
  );

  // Range table is plain storage with no reset
  always_ff @(posedge in_clock) begin
    if (in_wr_en) begin
      tab_start[in_wr_var][in_wr_idx] <= in_wr_start;
      tab_end[in_wr_var][in_wr_idx]   <= in_wr_end;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      for (int i = 0; i < int'(NUM_VARS); i++) size_q[i] <= '0;
    end else if (in_size_wr_en) begin
      size_q[in_wr_var] <= in_size;
    end
  end

  // Candidate draw and the deterministic fallback once the retry budget is spent
  assign draw      = lfsr_q[IDX_W-1:0] & mask_q;
  assign draw_wide = {1'b0, draw};
  assign draw_fits = draw_wide < count_q;
  assign fb_raw    = draw_fits ? draw : IDX_W'(draw_wide - count_q);

`ifdef DRS_EXCLUDE_CURRENT_EN
  logic [CNT_W-1:0] fb_inc;
  assign fb_inc     = {1'b0, fb_raw} + CNT_W'(1);
  assign draw_ok    = draw_fits && (draw != cur_q);
  assign fallback   = (fb_raw != cur_q) ? fb_raw :
                      ((fb_inc == count_q) ? '0 : IDX_W'(fb_inc));
  assign unused_sig = ^lfsr_q[LFSR_W-1:IDX_W];
`else
  assign draw_ok    = draw_fits;
  assign fallback   = fb_raw;
  assign unused_sig = ^{lfsr_q[LFSR_W-1:IDX_W], cur_q};
`endif

  always_comb begin
    state_d = state_q;
    var_d   = var_q;
    cur_d   = cur_q;
    count_d = count_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    idx_d   = idx_q;
    err_d   = err_q;
    lfsr_en = 1'b0;
    valid_d = out_valid;
    start_d = out_start;
    end_d   = out_end;
    index_d = out_index;
    equal_d = out_equal;
    error_d = out_error;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          var_d   = in_var;
          cur_d   = in_current_idx;
          state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        count_d = size_q[var_q];
        mask_d  = IDX_W'(smear(LFSR_W'(size_q[var_q]) - LFSR_W'(1)));
        tries_d = '0;
        err_d   = 1'b0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // Zero or one entry needs no randomness; still spend one cycle here
        if (count_q < CNT_W'(2)) begin
          idx_d   = '0;
          err_d   = (count_q == '0);
          state_d = S_LOOKUP;
        end else begin
          lfsr_en = 1'b1;
          if (draw_ok) begin
            idx_d   = draw;
            state_d = S_LOOKUP;
          end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            idx_d   = fallback;
            state_d = S_LOOKUP;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end
      end
      S_LOOKUP: begin
        valid_d = 1'b1;
        index_d = idx_q;
        error_d = err_q;
        if (err_q) begin
          start_d = '0;
          end_d   = '0;
          equal_d = 1'b1;
        end else begin
          start_d = tab_start[var_q][idx_q];
          end_d   = tab_end[var_q][idx_q];
          equal_d = (tab_start[var_q][idx_q] == tab_end[var_q][idx_q]);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (in_ready) begin
          valid_d = 1'b0;
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= S_IDLE;
      var_q     <= '0;
      cur_q     <= '0;
      count_q   <= '0;
      mask_q    <= '0;
      tries_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_ready <= 1'b1;
      out_start <= '0;
      out_end   <= '0;
      out_index <= '0;
      out_equal <= 1'b1;
      out_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      var_q     <= var_d;
      cur_q     <= cur_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      tries_q   <= tries_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      out_valid <= valid_d;
      out_ready <= ready_d;
      out_start <= start_d;
      out_end   <= end_d;
      out_index <= index_d;
      out_equal <= equal_d;
      out_error <= error_d;
    end
  end

endmodule

// File: tb/tb_discrete_range_sampler.sv
// Self-checking bench for discrete_range_sampler: spec-level model plus directed literal checks.
module tb_discrete_range_sampler;

`ifdef DRS_EXCLUDE_CURRENT_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] seed;
  logic        seed_load, wr_en, size_wr_en;
  logic [1:0]  wr_var, var_i;
  logic [3:0]  wr_idx, cur;
  logic [15:0] wr_start, wr_end;
  logic [4:0]  size;
  logic        valid, ready, valid1, ready1;
  logic        o_ready, o_valid, o_equal, o_error;
  logic [15:0] o_start, o_end;
  logic [3:0]  o_index;
  logic        p_ready, p_valid, p_equal, p_error;
  logic [15:0] p_start, p_end;
  logic [3:0]  p_index;

  always #5 clk = ~clk;

  discrete_range_sampler dut (
    .in_clock(clk), .in_reset_n(rst_n), .in_seed(seed), .in_seed_load(seed_load),
    .in_wr_en(wr_en), .in_wr_var(wr_var), .in_wr_idx(wr_idx), .in_wr_start(wr_start),
    .in_wr_end(wr_end), .in_size_wr_en(size_wr_en), .in_size(size), .in_valid(valid),
    .out_ready(o_ready), .in_var(var_i), .in_current_idx(cur), .out_valid(o_valid),
    .in_ready(ready), .out_start(o_start), .out_end(o_end), .out_index(o_index),
    .out_equal(o_equal), .out_error(o_error)
  );

  discrete_range_sampler #(.MAX_TRIES(1)) dut1 (
    .in_clock(clk), .in_reset_n(rst_n), .in_seed(seed), .in_seed_load(seed_load),
    .in_wr_en(wr_en), .in_wr_var(wr_var), .in_wr_idx(wr_idx), .in_wr_start(wr_start),
    .in_wr_end(wr_end), .in_size_wr_en(size_wr_en), .in_size(size), .in_valid(valid1),
    .out_ready(p_ready), .in_var(var_i), .in_current_idx(cur), .out_valid(p_valid),
    .in_ready(ready1), .out_start(p_start), .out_end(p_end), .out_index(p_index),
    .out_equal(p_equal), .out_error(p_error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model state: what the sampler must hold according to its rules
  int          m_size [4];
  int          m_ts   [4][16];
  int          m_te   [4][16];
  logic [15:0] m_lfsr;

  typedef struct {
    int idx; int s; int e; int err; int eq; int lat; int acc;
  } exp_t;
  exp_t q[$];
  bit   seen = 1'b0;
  int   got_idx, got_s, got_e, got_err, got_eq, got_lat;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic exp_t model(input int v, input int c);
    exp_t r;
    int cnt, mask, d, f;
    bit ok;
    cnt = m_size[v];
    r.err = 0; r.idx = 0; r.lat = 4; r.acc = 0;
    if (cnt == 0) r.err = 1;
    else if (cnt >= 2) begin
      mask = 0;
      while (mask < cnt - 1) mask = mask * 2 + 1;
      ok = 1'b0; d = 0;
      for (int t = 0; t < MT && !ok; t++) begin
        d = int'(m_lfsr) & mask;
        m_lfsr = lfsr_next(m_lfsr);
        r.lat = 4 + t;
        ok = (d < cnt) && !(EXCL && d == c);
      end
      if (ok) r.idx = d;
      else begin
        f = (d >= cnt) ? d - cnt : d;
        if (EXCL && f == c) f = (f + 1) % cnt;
        r.idx = f;
      end
    end
    r.s  = r.err ? 0 : m_ts[v][r.idx];
    r.e  = r.err ? 0 : m_te[v][r.idx];
    r.eq = (r.s == r.e) ? 1 : 0;
    return r;
  endfunction

  // Compare process: every cycle out_valid is up, outputs must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (q.size() == 0) check("spurious_valid", 32'(o_valid), 0);
      else begin
        if (!seen) begin
          seen = 1'b1;
          got_lat = cyc - q[0].acc;
          check("latency", 32'(got_lat), 32'(q[0].lat));
        end
        check("index", 32'(o_index), 32'(q[0].idx));
        check("start", 32'(o_start), 32'(q[0].s));
        check("end", 32'(o_end), 32'(q[0].e));
        check("error", 32'(o_error), 32'(q[0].err));
        check("equal", 32'(o_equal), 32'(q[0].eq));
        check("ready_busy", 32'(o_ready), 0);
        if (ready) begin
          got_idx = int'(o_index); got_s = int'(o_start); got_e = int'(o_end);
          got_err = int'(o_error); got_eq = int'(o_equal);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int v, input int i, input int s, input int e);
    wr_en = 1'b1; wr_var = 2'(v); wr_idx = 4'(i); wr_start = 16'(s); wr_end = 16'(e);
    tick();
    wr_en = 1'b0;
    m_ts[v][i] = s; m_te[v][i] = e;
  endtask

  task automatic wr_size(input int v, input int n);
    size_wr_en = 1'b1; wr_var = 2'(v); size = 5'(n);
    tick();
    size_wr_en = 1'b0;
    m_size[v] = n;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'h0001 : s;
  endtask

  task automatic request(input int v, input int c);
    exp_t e;
    int n = 0;
    while (!o_ready && n < 200) begin tick(); n++; end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 1);
    valid = 1'b1; var_i = 2'(v); cur = 4'(c);
    tick();
    valid = 1'b0;
    e = model(v, c);
    e.acc = cyc - 1;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 0);
      q.delete();
      seen = 1'b0;
    end
  endtask

  task automatic do_req(input int v, input int c);
    request(v, c);
    drain();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits, n;
    rst_n = 1'b0; seed = '0; seed_load = 0; wr_en = 0; size_wr_en = 0; wr_var = '0;
    wr_idx = '0; wr_start = '0; wr_end = '0; size = '0; valid = 0; var_i = '0; cur = '0;
    ready = 1'b1; valid1 = 1'b0; ready1 = 1'b1;
    m_lfsr = 16'h0001;
    for (int v = 0; v < 4; v++) m_size[v] = 0;
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_error", 32'(o_error), 0);
    check("rst_start", 32'(o_start), 0);
    check("rst_end", 32'(o_end), 0);
    check("rst_index", 32'(o_index), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr_entry(0, i, 'h100 + i, 'h200 + i);
      wr_entry(2, i, i * 10, i * 10 + 3);
    end
    wr_entry(1, 0, 7, 7);
    wr_entry(1, 1, 8, 9);
    wr_size(0, 16);
    wr_size(1, 1);
    wr_size(2, 5);

    // Zero seed behaves as 1: first draw of a 16-entry variable is index 1
    load_seed(16'h0000);
    do_req(0, 3);
    check("seed0_idx", 32'(got_idx), 1);
    check("seed0_start", 32'(got_s), 'h101);
    check("seed0_lat", 32'(got_lat), 4);

    // ACE1 -> E270 -> 7138: low nibbles 1, 0, 8
    load_seed(16'hACE1);
    do_req(0, 3); check("ace1_idx0", 32'(got_idx), 1);
    do_req(0, 3); check("ace1_idx1", 32'(got_idx), 0);
    do_req(0, 3); check("ace1_idx2", 32'(got_idx), 8);
    check("ace1_end2", 32'(got_e), 'h208);

    // Single entry: index 0 even when it is the current index
    do_req(1, 0);
    check("one_idx", 32'(got_idx), 0);
    check("one_equal", 32'(got_eq), 1);
    check("one_start", 32'(got_s), 7);
    check("one_lat", 32'(got_lat), 4);

    // Empty variable reports an error with zero range
    do_req(3, 0);
    check("empty_err", 32'(got_err), 1);
    check("empty_start", 32'(got_s), 0);
    check("empty_end", 32'(got_e), 0);
    check("empty_idle", 32'(o_ready), 1);

    load_seed(16'hACE1);
    hits = 0;
    for (int i = 0; i < 1000; i++) begin
      do_req(2, i % 5);
      check("r27_range", 32'(got_idx < 5), 1);
      check("r27_start", 32'(got_s), 32'(got_idx * 10));
      if (got_idx >= 0 && got_idx < 5) hits = hits | (1 << got_idx);
    end
    check("r27_all_hit", 32'(hits), 'h1F);

    wr_size(1, 2);
    for (int i = 0; i < 200; i++) begin
      do_req(1, 1);
      if (EXCL) check("excl_idx", 32'(got_idx), 0);
    end

    // Back-pressure: output held, no new accept while stalled
    ready = 1'b0;
    request(2, 0);
    n = 0;
    while (!o_valid && n < 50) begin tick(); n++; end
    check("hold_valid0", 32'(o_valid), 1);
    valid = 1'b1; var_i = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(o_valid), 1);
      check("hold_no_accept", 32'(o_ready), 0);
    end
    valid = 1'b0; ready = 1'b1;
    drain();
    check("hold_idle", 32'(o_ready), 1);

    // Reset while drawing abandons the request
    request(2, 1);
    tick();
    rst_n = 1'b0;
    q.delete(); seen = 1'b0;
    m_lfsr = 16'h0001;
    for (int v = 0; v < 4; v++) m_size[v] = 0;
    #1;
    check("rst_draw_valid", 32'(o_valid), 0);
    check("rst_draw_ready", 32'(o_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_quiet", 32'(o_valid), 0);
    end
    check("post_rst_ready", 32'(o_ready), 1);

    // Sizes were cleared by reset
    do_req(2, 0);
    check("post_rst_err", 32'(got_err), 1);

    // Single-try instance: draw 3 with 3 entries falls back to index 0
    wr_size(0, 3);
    load_seed(16'h0003);
    n = 0;
    while (!p_ready && n < 50) begin tick(); n++; end
    valid1 = 1'b1; var_i = 2'd0; cur = 4'd2;
    tick();
    valid1 = 1'b0;
    n = 0;
    while (!p_valid && n < 20) begin tick(); n++; end
    check("mt1_valid", 32'(p_valid), 1);
    check("mt1_lat", 32'(n + 1), 4);
    check("mt1_idx", 32'(p_index), 0);
    check("mt1_start", 32'(p_start), 'h100);
    check("mt1_end", 32'(p_end), 'h200);
    check("mt1_error", 32'(p_error), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
